// File: rtl/sd_sector_host.sv
// sd_sector_host
//   Single-sector transfer engine between a core-side 512-byte buffer and
//   the per-drive sector request interface of user_io (two drives, A/B).
//   A one-cycle req_rd/req_wr pulse latches the LBA and drive. The engine then
//   raises the drive's sd_rd/sd_wr bit until sd_ack and moves data while sd_ack
//   is high. It pulses done (plus error on timeout, unmounted drive or rejected
//   write) and then returns to idle.
//
// Parameters
//   TIMEOUT     clk_sys cycles to wait for sd_ack before aborting (24-bit)
//
// Configuration macro
//   SD_SECTOR_HOST_WRITE_EN  defined: sector writes are executed.
//                            undefined: sd_wr is tied low, sd_din is 8'h00,
//                            and an accepted write finishes immediately with error.
//
// Ports
//   clk_sys, reset            system clock, synchronous active-high reset
//   req_rd, req_wr            one-cycle request pulses (read wins on collision)
//   req_drive, req_lba        drive select (0=A, 1=B) and sector, sampled with request
//   busy, done, error         status: busy span, completion pulse, error pulse
//   buf_addr/din/we/dout      core-side buffer port (writes ignored while busy)
//   img_mounted, img_size     mount-event pulses per drive and image size
//   sd_lba, sd_rd, sd_wr      request lines to user_io
//   sd_ack, sd_buff_addr      user_io handshake and buffer address
//   sd_dout, sd_dout_strobe   sector data coming in (reads)
//   sd_din, sd_din_strobe     sector data going out (writes), 1-cycle latency
module sd_sector_host #(
  parameter logic [23:0] TIMEOUT = 24'd12_500_000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic        req_drive,
  input  logic [31:0] req_lba,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic [8:0]  buf_addr,
  input  logic [7:0]  buf_din,
  input  logic        buf_we,
  output logic [7:0]  buf_dout,
  input  logic [1:0]  img_mounted,
  input  logic [31:0] img_size,
  output logic [31:0] sd_lba,
  output logic [1:0]  sd_rd,
  output logic [1:0]  sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_dout,
  input  logic        sd_dout_strobe,
  output logic [7:0]  sd_din,
  input  logic        sd_din_strobe
);

`ifdef SD_SECTOR_HOST_WRITE_EN
  localparam bit WRITE_EN = 1'b1;
`else
  localparam bit WRITE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REQ, XFER, FIN} state_t;

  state_t      state, state_nx;
  logic [7:0]  mem [0:511];
  logic        drive;
  logic        op_wr;
  logic        err_flag;
  logic        sd_ack_d;
  logic [23:0] tmo_cnt;
  logic [1:0]  mounted;
  logic        accept, is_wr, reject, tmo_hit, ack_fall;
  logic        busy_nx, done_nx, error_nx;
  logic [1:0]  sd_wr_c;

  assign accept   = (state == IDLE) && (req_rd || req_wr);
  assign is_wr    = req_wr && !req_rd;
  assign reject   = !mounted[req_drive] || (is_wr && !WRITE_EN);
  assign tmo_hit  = (tmo_cnt == TIMEOUT - 24'd1);
  assign ack_fall = sd_ack_d && !sd_ack;

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = reject ? FIN : REQ;
      REQ: begin
        if (sd_ack)       state_nx = XFER;
        else if (tmo_hit) state_nx = FIN;
      end
      XFER: if (ack_fall) state_nx = FIN;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic: request lines are decoded straight from the state so that
  // leaving REQ (ack, timeout or reset) drops them on the same edge.
  always_comb begin
    sd_rd    = '0;
    sd_wr_c  = '0;
    busy_nx  = busy;
    done_nx  = 1'b0;
    error_nx = 1'b0;
    if (state == REQ) begin
      if (op_wr) sd_wr_c[drive] = 1'b1;
      else       sd_rd[drive]   = 1'b1;
    end
    if (accept) busy_nx = 1'b1;
    if (state == FIN) begin
      busy_nx  = 1'b0;
      done_nx  = 1'b1;
      error_nx = err_flag;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      busy  <= busy_nx;
      done  <= done_nx;
      error <= error_nx;
    end
  end

  // Request latches, timeout counter, ack edge detect, mount tracking
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sd_lba   <= '0;
      drive    <= 1'b0;
      op_wr    <= 1'b0;
      err_flag <= 1'b0;
      tmo_cnt  <= '0;
      sd_ack_d <= 1'b0;
      mounted  <= '0;
    end else begin
      sd_ack_d <= sd_ack;
      if (accept) begin
        sd_lba   <= req_lba;
        drive    <= req_drive;
        op_wr    <= is_wr;
        err_flag <= reject;
        tmo_cnt  <= '0;
      end else if (state == REQ) begin
        tmo_cnt <= tmo_cnt + 24'd1;
        if (!sd_ack && tmo_hit) err_flag <= 1'b1;
      end
      // Mount events are only recorded; an in-flight transfer is not aborted.
      for (int unsigned n = 0; n < 2; n++) begin
        if (img_mounted[n]) mounted[n] <= (img_size != '0);
      end
    end
  end

  // Buffer writes: the sd side writes only in XFER (busy=1) and the core side
  // only while busy=0, so the two write ports never collide.
  always_ff @(posedge clk_sys) begin
    if (state == XFER && !op_wr && sd_dout_strobe)
      mem[sd_buff_addr] <= sd_dout;
    else if (buf_we && !busy)
      mem[buf_addr] <= buf_din;
  end

  always_ff @(posedge clk_sys) begin
    buf_dout <= mem[buf_addr];
  end

`ifdef SD_SECTOR_HOST_WRITE_EN
  logic [7:0] sd_din_q;
  logic       unused_strobe;

  always_ff @(posedge clk_sys) begin
    sd_din_q <= mem[sd_buff_addr];
  end

  assign sd_din        = sd_din_q;
  assign sd_wr         = sd_wr_c;
  assign unused_strobe = sd_din_strobe;
`else
  logic [2:0] unused_bits;

  assign sd_din      = 8'h00;
  assign sd_wr       = 2'b00;
  assign unused_bits = {sd_din_strobe, sd_wr_c};
`endif

endmodule

// File: tb/tb_sd_sector_host.sv
// Directed bench for sd_sector_host (TIMEOUT overridden to 16).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_sd_sector_host;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        req_rd, req_wr, req_drive;
  logic [31:0] req_lba;
  logic        busy, done, error;
  logic [8:0]  buf_addr;
  logic [7:0]  buf_din;
  logic        buf_we;
  logic [7:0]  buf_dout;
  logic [1:0]  img_mounted;
  logic [31:0] img_size;
  logic [31:0] sd_lba;
  logic [1:0]  sd_rd, sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_dout;
  logic        sd_dout_strobe;
  logic [7:0]  sd_din;
  logic        sd_din_strobe;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt;
  int rd_extra;

  sd_sector_host #(.TIMEOUT(24'd16)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .req_rd         (req_rd),
    .req_wr         (req_wr),
    .req_drive      (req_drive),
    .req_lba        (req_lba),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .buf_addr       (buf_addr),
    .buf_din        (buf_din),
    .buf_we         (buf_we),
    .buf_dout       (buf_dout),
    .img_mounted    (img_mounted),
    .img_size       (img_size),
    .sd_lba         (sd_lba),
    .sd_rd          (sd_rd),
    .sd_wr          (sd_wr),
    .sd_ack         (sd_ack),
    .sd_buff_addr   (sd_buff_addr),
    .sd_dout        (sd_dout),
    .sd_dout_strobe (sd_dout_strobe),
    .sd_din         (sd_din),
    .sd_din_strobe  (sd_din_strobe)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; req_rd = 1'b0; req_wr = 1'b0; req_drive = 1'b0; req_lba = '0;
    buf_addr = '0; buf_din = '0; buf_we = 1'b0; img_mounted = '0; img_size = '0;
    sd_ack = 1'b0; sd_buff_addr = '0; sd_dout = '0; sd_dout_strobe = 1'b0;
    sd_din_strobe = 1'b0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_sd_rd", sd_rd, 0);
    chk("rst_sd_wr", sd_wr, 0);
    chk("rst_sd_lba", sd_lba, 0);
    reset = 1'b0;
    step();

    // Read to unmounted drive A: done+error two cycles after the request
    req_rd = 1'b1; req_drive = 1'b0; req_lba = 32'd7;
    step(); req_rd = 1'b0;
    chk("unm_busy", busy, 1);
    chk("unm_sd_rd0", sd_rd, 0);
    chk("unm_done_early", done, 0);
    step();
    chk("unm_done", done, 1);
    chk("unm_error", error, 1);
    chk("unm_busy_clr", busy, 0);
    chk("unm_sd_rd1", sd_rd, 0);
    chk("unm_lba", sd_lba, 7);
    step();
    chk("unm_done_1cyc", done, 0);

    // Mount drive A
    img_size = 32'd1024; img_mounted = 2'b01;
    step(); img_mounted = 2'b00;

    // Read sector 5 from drive A
    req_rd = 1'b1; req_drive = 1'b0; req_lba = 32'd5;
    step(); req_rd = 1'b0;
    chk("rd_busy", busy, 1);
    chk("rd_lba", sd_lba, 5);
    chk("rd_sd_rd", sd_rd, 2'b01);
    chk("rd_sd_wr", sd_wr, 0);
    step(); step();
    chk("rd_sd_rd_hold", sd_rd, 2'b01);
    sd_ack = 1'b1;
    step();
    chk("rd_sd_rd_ack", sd_rd, 0);
    for (int i = 0; i < 512; i++) begin
      sd_buff_addr = 9'(i); sd_dout = 8'(i) ^ 8'hA5; sd_dout_strobe = 1'b1;
      step();
    end
    sd_dout_strobe = 1'b0; sd_ack = 1'b0;
    step();
    chk("rd_done_wait", done, 0);
    chk("rd_busy_xfer", busy, 1);
    step();
    chk("rd_done", done, 1);
    chk("rd_error", error, 0);
    chk("rd_busy_clr", busy, 0);
    step();
    chk("rd_done_1cyc", done, 0);
    for (int i = 0; i < 512; i++) begin
      buf_addr = 9'(i);
      step();
      chk("rd_buf", buf_dout, 8'(i) ^ 8'hA5);
    end

    // Timeout: sd_rd high exactly 16 cycles; buf_we ignored while busy
    req_rd = 1'b1; req_drive = 1'b0; req_lba = 32'h77;
    step(); req_rd = 1'b0;
    buf_we = 1'b1; buf_addr = 9'd3; buf_din = 8'hEE;
    for (int k = 0; k < 16; k++) begin
      chk("tmo_sd_rd", sd_rd, 2'b01);
      step();
      buf_we = 1'b0;
    end
    chk("tmo_sd_rd_drop", sd_rd, 0);
    chk("tmo_done_wait", done, 0);
    chk("tmo_busy", busy, 1);
    step();
    chk("tmo_done", done, 1);
    chk("tmo_error", error, 1);
    chk("tmo_busy_clr", busy, 0);
    step();
    chk("tmo_busy_after", busy, 0);
    buf_addr = 9'd3;
    step();
    chk("busy_we_ignored", buf_dout, 8'hA6);

    // Simultaneous rd+wr, then a request while busy
    req_rd = 1'b1; req_wr = 1'b1; req_drive = 1'b0; req_lba = 32'h42;
    step(); req_rd = 1'b0; req_wr = 1'b0;
    chk("both_sd_rd", sd_rd, 2'b01);
    chk("both_sd_wr", sd_wr, 0);
    done_cnt = 0; rd_extra = 0;
    req_rd = 1'b1; req_lba = 32'h99;
    step(); req_rd = 1'b0;
    done_cnt += int'(done);
    chk("busy_req_lba", sd_lba, 32'h42);
    sd_ack = 1'b1;
    step(); sd_ack = 1'b0;
    done_cnt += int'(done);
    for (int k = 0; k < 10; k++) begin
      step();
      done_cnt += int'(done);
      if (sd_rd != 2'b00) rd_extra++;
    end
    chk("both_done_cnt", done_cnt, 1);
    chk("both_no_requeue", rd_extra, 0);

`ifdef SD_SECTOR_HOST_WRITE_EN
    // Write from buffer to drive B
    for (int i = 0; i < 512; i++) begin
      buf_we = 1'b1; buf_addr = 9'(i); buf_din = 8'(i);
      step();
    end
    buf_we = 1'b0;
    img_size = 32'd2048; img_mounted = 2'b10;
    step(); img_mounted = 2'b00;
    req_wr = 1'b1; req_drive = 1'b1; req_lba = 32'd9;
    step(); req_wr = 1'b0;
    chk("wr_sd_wr", sd_wr, 2'b10);
    chk("wr_sd_rd", sd_rd, 0);
    chk("wr_busy", busy, 1);
    sd_ack = 1'b1;
    step();
    chk("wr_sd_wr_ack", sd_wr, 0);
    for (int i = 0; i < 512; i++) begin
      sd_buff_addr = 9'(i); sd_din_strobe = 1'b1;
      step();
      chk("wr_sd_din", sd_din, 8'(i));
    end
    sd_din_strobe = 1'b0; sd_ack = 1'b0;
    step();
    chk("wr_done_wait", done, 0);
    step();
    chk("wr_done", done, 1);
    chk("wr_error", error, 0);
`else
    // Write rejected when writes are compiled out
    req_wr = 1'b1; req_drive = 1'b0; req_lba = 32'd9;
    step(); req_wr = 1'b0;
    chk("wr_rej_busy", busy, 1);
    chk("wr_rej_sd_wr", sd_wr, 0);
    step();
    chk("wr_rej_done", done, 1);
    chk("wr_rej_error", error, 1);
    chk("wr_rej_sd_wr1", sd_wr, 0);
`endif
    step();

    // Reset during XFER
    req_rd = 1'b1; req_drive = 1'b0; req_lba = 32'h55;
    step(); req_rd = 1'b0;
    sd_ack = 1'b1;
    step();
    sd_buff_addr = 9'd0; sd_dout = 8'h11; sd_dout_strobe = 1'b1;
    step(); sd_dout_strobe = 1'b0;
    reset = 1'b1;
    step(); reset = 1'b0;
    chk("xrst_sd_rd", sd_rd, 0);
    chk("xrst_busy", busy, 0);
    chk("xrst_done", done, 0);
    chk("xrst_lba", sd_lba, 0);
    sd_ack = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      done_cnt += int'(done);
    end
    chk("xrst_no_done", done_cnt, 0);

    // Later read completes; unmount during REQ is recorded only
    img_size = 32'd512; img_mounted = 2'b01;
    step(); img_mounted = 2'b00;
    req_rd = 1'b1; req_drive = 1'b0; req_lba = 32'd6;
    step(); req_rd = 1'b0;
    chk("post_sd_rd", sd_rd, 2'b01);
    chk("post_lba", sd_lba, 6);
    img_size = 32'd0; img_mounted = 2'b01;
    step(); img_mounted = 2'b00;
    chk("post_unmount_keep", sd_rd, 2'b01);
    sd_ack = 1'b1;
    step(); sd_ack = 1'b0;
    chk("post_sd_rd_ack", sd_rd, 0);
    step();
    chk("post_done_wait", done, 0);
    step();
    chk("post_done", done, 1);
    chk("post_error", error, 0);
    step();
    req_rd = 1'b1;
    step(); req_rd = 1'b0;
    chk("unm2_sd_rd", sd_rd, 0);
    step();
    chk("unm2_done", done, 1);
    chk("unm2_error", error, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
